// File: rtl/cmp_seq_if.sv
// Request/result bundle between a datapath and the
// nibble-serial compare controller.
interface cmp_seq_if #(
  parameter int NIBBLES = 4,
  parameter int CW      = $clog2(NIBBLES + 1)
);
  logic                 start;
  logic                 abort;
  logic [4*NIBBLES-1:0] a;
  logic [4*NIBBLES-1:0] b;
  logic                 busy;
  logic                 done;
  logic                 e;
  logic                 g;
  logic                 l;
  logic [CW-1:0]        nib_cnt;

  modport master (
    output start, abort, a, b,
    input  busy, done, e, g, l, nib_cnt
  );

  modport slave (
    input  start, abort, a, b,
    output busy, done, e, g, l, nib_cnt
  );
endinterface

// File: rtl/cmp_seq_ctrl.sv
// Nibble-serial unsigned magnitude compare, MSB nibble
// first, stopping at the first unequal nibble.
module cmp_seq_ctrl #(
  parameter int NIBBLES = 4,
  parameter int CW      = $clog2(NIBBLES + 1)
) (
  input logic      clk,
  input logic      rst_n,
  cmp_seq_if.slave bus
);
  localparam int W = 4 * NIBBLES;

  typedef enum logic {
    IDLE,
    CMP
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          e_q, e_d;
  logic          g_q, g_d;
  logic          l_q, l_d;
  logic          done_q, done_d;

  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [3:0]    na;
  logic [3:0]    nb;

  // the shared 4-bit slice sees the nibble at idx
  always_comb begin
    a_sh = a_q >> {idx_q, 2'b00};
    b_sh = b_q >> {idx_q, 2'b00};
    na   = a_sh[3:0];
    nb   = b_sh[3:0];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    g_d     = g_q;
    l_d     = l_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          idx_d   = CW'(NIBBLES - 1);
          cnt_d   = '0;
          e_d     = 1'b0;
          g_d     = 1'b0;
          l_d     = 1'b0;
          state_d = CMP;
        end
      end
      CMP: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (na != nb) begin
          g_d     = (na > nb);
          l_d     = (na < nb);
          cnt_d   = CW'(NIBBLES) - idx_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (idx_q == '0) begin
          e_d     = 1'b1;
          cnt_d   = CW'(NIBBLES);
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      g_q     <= 1'b0;
      l_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      g_q     <= g_d;
      l_q     <= l_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy    = (state_q == CMP);
  assign bus.done    = done_q;
  assign bus.e       = e_q;
  assign bus.g       = g_q;
  assign bus.l       = l_q;
  assign bus.nib_cnt = cnt_q;
endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Bench for cmp_seq_ctrl: vector table, corner sequences
// and random operands against a whole-word compare model.
module tb_cmp_seq_ctrl;
  localparam int N  = 4;
  localparam int W  = 4 * N;
  localparam int CW = $clog2(N + 1);

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  cmp_seq_if #(.NIBBLES(N), .CW(CW)) bus ();

  cmp_seq_ctrl #(.NIBBLES(N), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         e;
    logic         g;
    logic         l;
    int           k;
  } vec_t;

  vec_t vt[8];

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // whole-word reference: result from the full compare,
  // count from the nibble holding the top differing bit
  task automatic ref_model(input logic [W-1:0] a,
                           input logic [W-1:0] b,
                           output logic e, output logic g,
                           output logic l, output int k);
    logic [W-1:0] x;
    int p;
    x = a ^ b;
    e = (a == b);
    g = (a > b);
    l = (a < b);
    p = -1;
    for (int i = 0; i < W; i++)
      if (x[i]) p = i;
    k = (p < 0) ? N : N - p / 4;
  endtask

  task automatic run_cmp(string nm, logic [W-1:0] a,
                         logic [W-1:0] b, logic xe,
                         logic xg, logic xl, int xk);
    int lat;
    int bcnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    chk({nm, " egl_busy"}, {bus.e, bus.g, bus.l}, 0);
    lat  = 0;
    bcnt = 0;
    while (!bus.done && lat < 64) begin
      if (bus.busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    chk({nm, " done"}, bus.done, 1);
    chk({nm, " latency"}, lat, xk);
    chk({nm, " busy_cycles"}, bcnt, xk);
    chk({nm, " busy_at_done"}, bus.busy, 0);
    chk({nm, " e"}, bus.e, xe);
    chk({nm, " g"}, bus.g, xg);
    chk({nm, " l"}, bus.l, xl);
    chk({nm, " nib_cnt"}, bus.nib_cnt, xk);
    @(negedge clk);
    chk({nm, " done_1cyc"}, bus.done, 0);
    chk({nm, " hold"},
        {bus.e, bus.g, bus.l, bus.nib_cnt},
        {xe, xg, xl, CW'(xk)});
  endtask

  initial begin
    int lat;
    int nd;
    int t[$];
    logic re;
    logic rg;
    logic rl;
    int rk;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] m;
    int j;

    n_cmp = 0;
    n_bad = 0;
    vt[0] = '{16'h0000, 16'h0002, 0, 0, 1, 4};
    vt[1] = '{16'h8000, 16'h8000, 1, 0, 0, 4};
    vt[2] = '{16'hF000, 16'h0000, 0, 1, 0, 1};
    vt[3] = '{16'h1B00, 16'h1A00, 0, 1, 0, 2};
    vt[4] = '{16'hFFFF, 16'hFFFE, 0, 1, 0, 4};
    vt[5] = '{16'h0001, 16'h00B1, 0, 0, 1, 3};
    vt[6] = '{16'h7FFF, 16'h8000, 0, 0, 1, 1};
    vt[7] = '{16'h1230, 16'h1234, 0, 0, 1, 4};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    chk("reset outs",
        {bus.busy, bus.done, bus.e, bus.g, bus.l, bus.nib_cnt}, 0);
    rst_n = 1'b1;

    foreach (vt[i])
      run_cmp($sformatf("vec%0d", i), vt[i].a, vt[i].b,
              vt[i].e, vt[i].g, vt[i].l, vt[i].k);

    // start during busy is ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h1B00;
    bus.b     = 16'h1A00;
    @(negedge clk);
    bus.a = 16'h0000;
    bus.b = 16'hFFFF;
    chk("ign busy", bus.busy, 1);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("ign done", bus.done, 1);
    chk("ign egl", {bus.e, bus.g, bus.l}, 3'b010);
    chk("ign cnt", bus.nib_cnt, 2);
    @(negedge clk);
    chk("ign idle", bus.busy, 0);

    // abort in the second CMP cycle
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h0001;
    bus.b     = 16'h00B1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("abt busy_pre", bus.busy, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abt busy", bus.busy, 0);
    chk("abt outs",
        {bus.done, bus.e, bus.g, bus.l, bus.nib_cnt}, 0);
    nd = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    chk("abt no_done", nd, 0);
    run_cmp("abt after", 16'h0001, 16'h00B1, 0, 0, 1, 3);

    // reset in the third CMP cycle
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h1234;
    bus.b     = 16'h1234;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst outs",
        {bus.busy, bus.done, bus.e, bus.g, bus.l, bus.nib_cnt}, 0);
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    chk("rst no_done", nd, 0);
    rst_n = 1'b1;
    run_cmp("rst after", 16'hFFFF, 16'hFFFE, 0, 1, 0, 4);

    // start held: one accept per k+1 edges
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = '0;
    bus.b     = '0;
    nd = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.done) begin
        nd++;
        t.push_back(c);
        chk($sformatf("b2b e@%0d", c), bus.e, 1);
      end
    end
    bus.start = 1'b0;
    chk("b2b count", nd, 4);
    if (t.size() > 0) chk("b2b first", t[0], 5);
    for (int i = 1; i < t.size(); i++)
      chk($sformatf("b2b gap%0d", i), t[i] - t[i-1], 5);
    @(negedge clk);
    @(negedge clk);
    chk("b2b idle", bus.busy, 0);

    // random operands sharing a random-length prefix
    for (int r = 0; r < 150; r++) begin
      ra = W'($urandom);
      j  = $urandom_range(0, N - 1);
      m  = {W{1'b1}} << (4 * (j + 1));
      if ($urandom_range(0, 4) == 0)
        rb = ra;
      else
        rb = (ra & m) | (W'($urandom) & ~m);
      ref_model(ra, rb, re, rg, rl, rk);
      run_cmp($sformatf("rnd%0d", r), ra, rb, re, rg, rl, rk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cmp_seq_ctrl.md
Name: cmp_seq_ctrl

Overview:
- Nibble-serial magnitude comparator controller for wide operands.
- Reuses one 4-bit compare slice (e/g/l semantics) to compare two 4*NIBBLES-bit unsigned words.
- Compares MSB nibble first and terminates early on the first unequal nibble.
- Sits between a requesting datapath (start/done handshake) and the shared 4-bit compare logic.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand (operand width W = 4*NIBBLES); legal range 1..16.
- CW, $clog2(NIBBLES+1), width of the nibble index and count fields.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when busy=0
- abort  input  1  cancels an in-progress compare
- a  input  W  operand A (unsigned), sampled on accept
- b  input  W  operand B (unsigned), sampled on accept
- busy  output  1  high while a compare is in progress
- done  output  1  one-cycle pulse when the result is valid
- e  output  1  A==B
- g  output  1  A>B
- l  output  1  A<B
- nib_cnt  output  CW  number of nibbles examined for the last result

Behaviour:
- Reset, asynchronous on rst_n=0:
  - state=IDLE.
  - busy, done, e, g, l, nib_cnt all 0.
  - Internal operand registers and index cleared.
- States:
  - IDLE:
    - start=1 at a clock edge -> latch a and b, idx=NIBBLES-1, e/g/l cleared to 000, nib_cnt=0, busy=1, go to CMP.
    - abort is ignored in IDLE.
  - CMP: one nibble per cycle, on slice [4*idx+3 : 4*idx] of the latched operands.
    - Nibbles unequal -> set g=1 or l=1, nib_cnt=NIBBLES-idx, done=1, busy=0, go to IDLE.
    - Nibbles equal and idx=0 -> e=1, nib_cnt=NIBBLES, done=1, busy=0, go to IDLE.
    - Nibbles equal and idx>0 -> idx decrements, stay in CMP.
- Latency:
  - done rises k clock edges after the edge that accepted start, where k is the number of nibbles examined (1..NIBBLES).
  - busy is high for exactly k cycles.
- done lasts exactly one cycle.
- e, g, l and nib_cnt hold their values until the next accepted start.
- Exactly one of e/g/l is high after any done; all three are 0 while busy.
- start while busy=1 is ignored; the latched operands do not change.
- start in the same cycle that done pulses is not accepted, because busy is still high on that edge. Back-to-back throughput is one request per k+1 cycles.
- abort=1 in CMP:
  - Next state is IDLE, busy=0, no done pulse.
  - e/g/l stay 000; nib_cnt stays 0.
  - abort takes priority over a completing compare on the same edge.
- Operand changes on a/b after acceptance have no effect.
- Reset asserted mid-compare returns to reset values immediately; no done is generated.
- Compare is unsigned. The MSB nibble decides first; lower nibbles are never examined once a difference is found.

Test Plan (NIBBLES=4):
- a=0x0000, b=0x0002, start -> busy for 4 cycles, done 4 edges after accept, l=1, e=g=0, nib_cnt=4.
- a=0x8000, b=0x8000 -> done after 4 edges, e=1, nib_cnt=4; then a=0xF000, b=0x0000 -> done after 1 edge, g=1, nib_cnt=1.
- a=0x1B00, b=0x1A00 -> done after 2 edges, g=1, nib_cnt=2. Re-assert start during busy with a=0x0000, b=0xFFFF -> ignored; the result is still g=1.
- a=0x0001, b=0x00B1, start, then abort on the 2nd cycle of CMP -> no done, busy falls next edge, e=g=l=0; a following start compares normally.
- Start a=0x1234, b=0x1234, assert rst_n=0 in the 3rd CMP cycle -> all outputs 0 immediately, no done; after release, a=0xFFFF, b=0xFFFE -> done after 4 edges, g=1.
- start held high continuously with a=0x0000, b=0x0000 -> accepts every 5th edge; done pulses every 5 cycles with e=1 each time.
